// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: Moore outputs registered alongside state,
// with a bounded memory-wait timeout that parks the machine in ERR.
module multicycle_ctrl #(
  parameter int OPW     = 6,
  parameter int FW      = 6,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic [FW-1:0]   funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_update,
  output logic [1:0]      pc_src,
  output logic [ALUW-1:0] alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write,
  output logic            sp_sel,
  output logic            sp_update,
  output logic            sp_dec,
  output logic            halted,
  output logic            err,
  output logic            illegal,
  output logic [3:0]      state
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_LD   = OPW'(10);
  localparam logic [OPW-1:0] OP_ST   = OPW'(11);
  localparam logic [OPW-1:0] OP_BZ   = OPW'(12);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(13);
  localparam logic [OPW-1:0] OP_PUSH = OPW'(14);
  localparam logic [OPW-1:0] OP_POP  = OPW'(15);
  localparam logic [OPW-1:0] OP_HALT = OPW'(63);

  typedef enum logic [3:0] {
    START = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC = 4'd3, MEM = 4'd4,
    WB = 4'd5, DONE = 4'd6, HALT = 4'd7, ERR = 4'd8
  } state_t;

  typedef struct packed {
    logic            pcUpdate;
    logic [1:0]      pcSrc;
    logic [ALUW-1:0] aluOp;
    logic            aluSrc;
    logic            regWrite;
    logic            regDst;
    logic            memToReg;
    logic            memRead;
    logic            memWrite;
    logic            spSel;
    logic            spUpdate;
    logic            spDec;
    logic            halted;
    logic            err;
    logic            illegal;
  } ctrl_t;

  function automatic logic isAlu(input logic [OPW-1:0] op);
    return op <= OPW'(9);
  endfunction

  function automatic logic isMem(input logic [OPW-1:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_PUSH) || (op == OP_POP);
  endfunction

  function automatic logic isLegal(input logic [OPW-1:0] op);
    return isAlu(op) || isMem(op) || (op == OP_BZ) || (op == OP_JMP);
  endfunction

  state_t         st;
  ctrl_t          ctl;
  logic [OPW-1:0] opReg;
  logic [CW-1:0]  cnt;

  ctrl_t decCtl, clrCtl, fetchCtl, brCtl, memWbCtl, memDoneCtl, haltCtl, errCtl;
  logic  isLoad;

  assign isLoad = (opReg == OP_LD) || (opReg == OP_POP);

  // Next-value templates for each transition; the FSM only picks among them.
  always_comb begin
    decCtl = '0;
    if (opcode == OP_R) begin
      decCtl.aluOp  = ALUW'(funct);
      decCtl.aluSrc = 1'b1;
    end else if (isAlu(opcode)) begin
      decCtl.aluOp = ALUW'(opcode - OPW'(1));
    end
    decCtl.illegal = !isLegal(opcode) && (opcode != OP_HALT);

    clrCtl       = '0;
    clrCtl.pcSrc = ctl.pcSrc;

    fetchCtl          = clrCtl;
    fetchCtl.pcUpdate = 1'b1;

    brCtl       = '0;
    brCtl.pcSrc = (opReg == OP_JMP) ? 2'd2 : (zero ? 2'd1 : 2'd0);

    memWbCtl          = '0;
    memWbCtl.regWrite = 1'b1;
    memWbCtl.memToReg = 1'b1;
    memWbCtl.spUpdate = (opReg == OP_POP);

    memDoneCtl          = clrCtl;
    memDoneCtl.spUpdate = (opReg == OP_PUSH);
    memDoneCtl.spDec    = (opReg == OP_PUSH);

    haltCtl        = '0;
    haltCtl.halted = 1'b1;

    errCtl     = '0;
    errCtl.err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= START;
      ctl   <= '0;
      opReg <= '0;
      cnt   <= '0;
    end else begin
      case (st)
        START: begin
          st  <= FETCH;
          ctl <= fetchCtl;
        end
        // opcode is stable from FETCH, so decode outputs are ready in DECODE
        FETCH: begin
          st    <= DECODE;
          opReg <= opcode;
          ctl   <= decCtl;
        end
        DECODE: begin
          if (opReg == OP_HALT) begin
            st  <= HALT;
            ctl <= haltCtl;
          end else if (!isLegal(opReg)) begin
            st  <= DONE;
            ctl <= clrCtl;
          end else begin
            st <= EXEC;
          end
        end
        EXEC: begin
          if (isAlu(opReg)) begin
            st           <= WB;
            ctl.regWrite <= 1'b1;
            ctl.regDst   <= (opReg == OP_R);
          end else if (isMem(opReg)) begin
            st           <= MEM;
            cnt          <= '0;
            ctl.memRead  <= isLoad;
            ctl.memWrite <= !isLoad;
            ctl.spSel    <= (opReg == OP_PUSH) || (opReg == OP_POP);
          end else begin
            st  <= DONE;
            ctl <= brCtl;
          end
        end
        // ready on the last allowed cycle still completes the access
        MEM: begin
          if (mem_ready) begin
            if (isLoad) begin
              st  <= WB;
              ctl <= memWbCtl;
            end else begin
              st  <= DONE;
              ctl <= memDoneCtl;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            st  <= ERR;
            ctl <= errCtl;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WB: begin
          st  <= DONE;
          ctl <= clrCtl;
        end
        DONE: begin
          st  <= FETCH;
          ctl <= fetchCtl;
        end
        HALT, ERR: ;
        default: begin
          st  <= START;
          ctl <= '0;
        end
      endcase
    end
  end

  assign state      = st;
  assign pc_update  = ctl.pcUpdate;
  assign pc_src     = ctl.pcSrc;
  assign alu_op     = ctl.aluOp;
  assign alu_src    = ctl.aluSrc;
  assign reg_write  = ctl.regWrite;
  assign reg_dst    = ctl.regDst;
  assign mem_to_reg = ctl.memToReg;
  assign mem_read   = ctl.memRead;
  assign mem_write  = ctl.memWrite;
  assign sp_sel     = ctl.spSel;
  assign sp_update  = ctl.spUpdate;
  assign sp_dec     = ctl.spDec;
  assign halted     = ctl.halted;
  assign err        = ctl.err;
  assign illegal    = ctl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction trace model queues the
// expected output vector of every cycle, and literal checks pin CPI and strobes.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_update, alu_src, reg_write, reg_dst, mem_to_reg, mem_read, mem_write;
  logic       sp_sel, sp_update, sp_dec, halted, err, illegal;
  logic [1:0] pc_src;
  logic [3:0] alu_op, state;

  multicycle_ctrl #(.OPW(6), .FW(6), .ALUW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_update(pc_update), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .sp_sel(sp_sel), .sp_update(sp_update),
    .sp_dec(sp_dec), .halted(halted), .err(err), .illegal(illegal), .state(state)
  );

  typedef struct {
    logic [3:0] st;
    logic       pcU;
    logic [1:0] pcSrc;
    logic [3:0] aluOp;
    logic       aluSrc, regW, regDst, m2r, mRd, mWr, spSel, spUpd, spDec, halted, err, illegal;
    logic       memReady, zero;
  } rec_t;

  rec_t       q[$];
  logic [1:0] mPc;
  int         checks, errors, cyc;
  int         instrCyc, rdCnt, wrCnt, regWrCnt, regDstCnt, m2rCnt, illCnt, haltCnt;
  int         memCyc, spUpdCnt, execAlu, fetchPcSrc;

  logic [22:0] got;
  assign got = {state, pc_update, pc_src, alu_op, alu_src, reg_write, reg_dst, mem_to_reg,
                mem_read, mem_write, sp_sel, sp_update, sp_dec, halted, err, illegal};

  function automatic logic [22:0] packRec(input rec_t r);
    return {r.st, r.pcU, r.pcSrc, r.aluOp, r.aluSrc, r.regW, r.regDst, r.m2r,
            r.mRd, r.mWr, r.spSel, r.spUpd, r.spDec, r.halted, r.err, r.illegal};
  endfunction

  function automatic rec_t mk(input logic [3:0] s);
    rec_t r;
    r = '{default: '0};
    r.st = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, g, e);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Apply the inputs that belong to the cycle at the head of the queue.
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mem_ready = q[0].memReady;
      zero      = q[0].zero;
    end
  end

  // Compare process plus per-instruction statistics.
  initial forever begin
    rec_t r;
    @(negedge clk);
    if (rst_n) begin
      cyc++;
      if (state == 4'd1) begin
        instrCyc = 0; rdCnt = 0; wrCnt = 0; regWrCnt = 0; regDstCnt = 0; m2rCnt = 0;
        illCnt = 0; haltCnt = 0; memCyc = 0; spUpdCnt = 0; execAlu = -1;
        fetchPcSrc = int'(pc_src);
      end
      instrCyc++;
      rdCnt     += int'(mem_read);
      wrCnt     += int'(mem_write);
      regWrCnt  += int'(reg_write);
      regDstCnt += int'(reg_dst & reg_write);
      m2rCnt    += int'(mem_to_reg & reg_write);
      illCnt    += int'(illegal);
      haltCnt   += int'(halted);
      spUpdCnt  += int'(sp_update);
      memCyc    += int'(state == 4'd4);
      if (state == 4'd3) execAlu = int'(alu_op);
      if (q.size() != 0) begin
        r = q.pop_front();
        checks++;
        if (got !== packRec(r)) begin
          errors++;
          $display("FAIL cycle %0d state=%0d: got %h expected %h", cyc, r.st, got, packRec(r));
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Queue the expected trace of one instruction, then wait for it to play out.
  task automatic run(input int op, input int fn, input logic z, input int waits,
                     input int tailN = 4, input int memCap = 1000);
    rec_t r;
    logic [5:0] fv;
    logic isR, isImm, isMem, legal, rd;
    fv = 6'(fn);
    opcode = 6'(op); funct = fv;
    isR = (op == 0); isImm = (op >= 1 && op <= 9);
    isMem = (op == 10 || op == 11 || op == 14 || op == 15);
    legal = isR || isImm || isMem || op == 12 || op == 13;
    r = mk(4'd1); r.pcU = 1'b1; r.pcSrc = mPc; q.push_back(r);
    r = mk(4'd2);
    if (isR) begin r.aluOp = fv[3:0]; r.aluSrc = 1'b1; end
    else if (isImm) r.aluOp = 4'(op - 1);
    r.illegal = !legal && op != 63;
    q.push_back(r);
    mPc = 2'd0;
    if (op == 63) begin
      repeat (tailN) begin r = mk(4'd7); r.halted = 1'b1; q.push_back(r); end
    end else if (!legal) begin
      q.push_back(mk(4'd6));
    end else begin
      r.st = 4'd3; r.zero = z; q.push_back(r);
      if (isR || isImm) begin
        r.zero = 1'b0; r.st = 4'd5; r.regW = 1'b1; r.regDst = isR; q.push_back(r);
        q.push_back(mk(4'd6));
      end else if (!isMem) begin
        r = mk(4'd6); r.pcSrc = (op == 13) ? 2'd2 : (z ? 2'd1 : 2'd0);
        mPc = r.pcSrc; q.push_back(r);
      end else begin
        rd = (op == 10 || op == 15);
        for (int i = 0; i <= waits && i < TO && i < memCap; i++) begin
          r = mk(4'd4); r.mRd = rd; r.mWr = !rd; r.spSel = (op == 14 || op == 15);
          r.memReady = (i == waits); q.push_back(r);
        end
        if (memCap > waits) begin
          if (waits >= TO) begin
            repeat (tailN) begin r = mk(4'd8); r.err = 1'b1; q.push_back(r); end
          end else if (rd) begin
            r = mk(4'd5); r.regW = 1'b1; r.m2r = 1'b1; r.spUpd = (op == 15); q.push_back(r);
            q.push_back(mk(4'd6));
          end else begin
            r = mk(4'd6); r.spUpd = (op == 14); r.spDec = (op == 14); q.push_back(r);
          end
        end
      end
    end
    drain();
  endtask

  task automatic doReset(input logic expectMem);
    @(posedge clk);
    #2;
    if (expectMem) chk("state before reset", state, 4);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", got, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mPc = 2'd0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mPc = 2'd0;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset outputs", got, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(0, 6'h03, 1'b0, 0);
    chk("R alu_op in EXEC", execAlu, 3);
    chk("R reg_write cycles", regWrCnt, 1);
    chk("R reg_dst cycles", regDstCnt, 1);
    chk("R CPI", instrCyc, 5);

    run(5, 0, 1'b0, 0);
    chk("imm alu_op", execAlu, 4);
    chk("imm CPI", instrCyc, 5);

    run(10, 0, 1'b0, 3);
    chk("LD mem_read cycles", rdCnt, 4);
    chk("LD mem_to_reg", m2rCnt, 1);
    chk("LD CPI", instrCyc, 9);

    run(12, 0, 1'b1, 0);
    chk("BZ CPI", instrCyc, 4);
    run(1, 0, 1'b0, 0);
    chk("BZ taken pc_src at FETCH", fetchPcSrc, 1);
    run(12, 0, 1'b0, 0);
    run(1, 0, 1'b0, 0);
    chk("BZ not taken pc_src", fetchPcSrc, 0);
    run(13, 0, 1'b0, 0);
    run(2, 0, 1'b0, 0);
    chk("JMP pc_src at FETCH", fetchPcSrc, 2);

    run(15, 0, 1'b0, 0);
    chk("POP CPI", instrCyc, 6);
    chk("POP sp_update", spUpdCnt, 1);
    run(14, 0, 1'b0, 2);
    chk("PUSH CPI", instrCyc, 7);
    chk("PUSH sp_update", spUpdCnt, 1);

    run(11, 0, 1'b0, TO - 1);
    chk("ST ready on last cycle CPI", instrCyc, 20);
    chk("ST mem_write cycles", wrCnt, 16);

    run(40, 0, 1'b0, 0);
    chk("illegal CPI", instrCyc, 3);
    chk("illegal pulse", illCnt, 1);
    chk("illegal strobes", regWrCnt + rdCnt + wrCnt, 0);

    run(11, 0, 1'b0, TO, 4);
    chk("timeout MEM cycles", memCyc, 16);
    doReset(1'b0);

    run(63, 0, 1'b0, 0, 100);
    chk("halted cycles", haltCnt, 100);
    doReset(1'b0);

    run(14, 0, 1'b0, 5, 4, 2);
    doReset(1'b1);
    run(40, 0, 1'b0, 0);
    chk("post-reset illegal CPI", instrCyc, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- OPW, 6: opcode width.
- FW, 6: funct width.
- ALUW, 4: alu_op width; ALUW SHALL be no greater than FW.
- TIMEOUT, 16: maximum number of MEM cycles without mem_ready before the error state; TIMEOUT SHALL be at least 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset; one clock, asynchronous, active-low.
- opcode, in, OPW: instruction opcode; stable from FETCH until DONE.
- funct, in, FW: R-type function field.
- zero, in, 1: ALU zero flag, sampled in EXEC.
- mem_ready, in, 1: memory access completion, sampled in MEM.
- pc_update, out, 1: PC load strobe.
- pc_src, out, 2: next-PC select; 0 = +4, 1 = branch target, 2 = jump target.
- alu_op, out, ALUW: ALU operation.
- alu_src, out, 1: 1 = register operand, 0 = immediate operand.
- reg_write, out, 1: register file write enable.
- reg_dst, out, 1: 1 = rd, 0 = rt.
- mem_to_reg, out, 1: write-back data select.
- mem_read, out, 1: memory read request.
- mem_write, out, 1: memory write request.
- sp_sel, out, 1: memory address taken from SP.
- sp_update, out, 1: SP adjust strobe.
- sp_dec, out, 1: 1 = decrement SP, 0 = increment SP.
- halted, out, 1: processor halted.
- err, out, 1: memory timeout error.
- illegal, out, 1: pulse on an undefined opcode.
- state, out, 4: current state, for debug.
REQ-003 All outputs SHALL be registered (Moore); no output SHALL be combinationally dependent on inputs.

Function
REQ-004 States and encodings: START=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, DONE=6, HALT=7, ERR=8.
REQ-005 START SHALL go to FETCH on the next edge.
REQ-006 FETCH SHALL assert pc_update for exactly 1 cycle, using the pc_src value registered by the previous instruction, then go to DECODE.
REQ-007 DECODE SHALL latch opcode and funct internally and reset pc_src to 0.
- Opcode 0 (R-type): alu_op = funct[ALUW-1:0], alu_src = 1.
- Opcodes 1..9 (immediate ALU): alu_op = opcode-1, alu_src = 0.
- Opcodes 10 (LD), 11 (ST), 14 (PUSH), 15 (POP): alu_op = 0, alu_src = 0.
- Opcode 63 (HALT): next state HALT.
- Any other opcode: illegal pulses for 1 cycle, then DONE (executed as a NOP).
REQ-008 EXEC next state:
- Opcodes 0..9: WB.
- LD, ST, PUSH, POP: MEM.
- Opcode 12 (BZ): pc_src = 1 if zero = 1, else 0; then DONE.
- Opcode 13 (JMP): pc_src = 2; then DONE.
REQ-009 MEM SHALL hold its request while waiting:
- mem_read = 1 for LD and POP; mem_write = 1 for ST and PUSH.
- sp_sel = 1 for PUSH and POP.
- The request SHALL be held every MEM cycle until mem_ready = 1 is sampled.
REQ-010 MEM exit conditions:
- A wait counter increments on each MEM cycle with mem_ready = 0.
- If mem_ready = 0 when the counter equals TIMEOUT-1, the next state SHALL be ERR.
- If mem_ready = 1 on that same cycle, ready SHALL win and the FSM SHALL proceed normally.
- The counter SHALL clear on every MEM entry.
REQ-011 Exit from MEM clears mem_read, mem_write and sp_sel, then:
- LD and POP go to WB.
- ST goes to DONE.
- PUSH goes to DONE with sp_update = 1 and sp_dec = 1.
REQ-012 WB SHALL assert reg_write for exactly 1 cycle.
- reg_dst = 1 only for R-type.
- mem_to_reg = 1 for LD and POP.
- POP also asserts sp_update = 1 with sp_dec = 0.
- Next state is DONE.
REQ-013 DONE SHALL clear every control output except pc_src, halted and err, then go to FETCH.
REQ-014 Cycles per instruction:
- R-type and immediate: 5.
- LD and POP: 6 + wait cycles.
- ST and PUSH: 5 + wait cycles.
- BZ and JMP: 4.
- Illegal: 3 (FETCH, DECODE, DONE).
REQ-015 HALT SHALL assert halted = 1 and hold all other outputs at 0 until reset.
REQ-016 ERR SHALL assert err = 1 and hold all other outputs at 0 until reset.
REQ-017 reg_write, mem_read and mem_write SHALL never be asserted in the same cycle.

Reset
REQ-018 rst_n = 0 SHALL immediately force state = START and every output to 0 (pc_src = 0, counter = 0), including when asserted mid-MEM or mid-WB.
REQ-019 After rst_n deasserts, the first rising edge SHALL enter FETCH.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R-type, opcode=0, funct=0x03: state sequence 1,2,3,5,6; alu_op=3 in EXEC; reg_write=1 and reg_dst=1 for 1 cycle in WB.
- LD (opcode=10), mem_ready low for 3 MEM cycles: mem_read high for 4 cycles; WB with mem_to_reg=1; next FETCH 9 cycles after the first FETCH.
- BZ (opcode=12), zero=1: the following FETCH has pc_update=1 with pc_src=1; with zero=0, pc_src=0.
- ST with TIMEOUT=16 and mem_ready held 0: ERR entered after 16 MEM cycles, err=1, mem_write=0; mem_ready=1 on the 16th cycle goes to DONE instead.
- opcode=63: halted=1 persists for 100 cycles; rst_n pulsed low during MEM of a PUSH: all outputs 0 asynchronously, FETCH on the first edge after release.
- opcode=40: illegal pulses 1 cycle; no reg_write or memory strobe; next FETCH 3 cycles after the first.
